imem_fetch_ctrl: RTL

//  Instruction-fetch sequencer for the single-cycle core's 256x16 instruction memory (IMemBank).

---
 rtl/imem_fetch_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Instruction-fetch sequencer for the 256x16 instruction memory. Owns the
//   PC, drives the memory address/read strobe, and buffers fetched words in a
//   small prefetch FIFO that decode drains through a valid/ready handshake.
//   A redirect flushes the FIFO and reloads the PC; start/halt sequence the
//   IDLE -> RUN -> HALT -> RUN state machine.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, halt           run/halt control
//   redirect, redirect_pc flush FIFO and reload PC
//   imem_read, imem_addr  read strobe and address to the instruction memory
//   imem_rdata            combinational read data for imem_addr
//   dec_valid/ready       handshake with decode for the FIFO head
//   dec_instr, dec_pc     head instruction and the address it came from
//   fifo_count            current FIFO occupancy
//   running               high while in RUN
// ----------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     redirect,
    input  logic [7:0]               redirect_pc,
    output logic                     imem_read,
    output logic [7:0]               imem_addr,
    input  logic [15:0]              imem_rdata,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [15:0]              dec_instr,
    output logic [7:0]               dec_pc,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     running
);

    localparam int             PW         = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      pc;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic [15:0]     buf_instr [DEPTH];
    logic [7:0]      buf_pc    [DEPTH];

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A redirect freezes the state for its cycle; halt
    // beats start when both arrive in RUN.
    // ------------------------------------------------------------------
    // NOTE: state_next is defaulted before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (!redirect) begin
            unique case (state)
                ST_IDLE: if (start) state_next = ST_RUN;
                ST_RUN:  if (halt)  state_next = ST_HALT;
                ST_HALT: if (start) state_next = ST_RUN;
                default:            state_next = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Fetch / handshake decode
    // ------------------------------------------------------------------
    assign running   = (state == ST_RUN);
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign dec_valid = !empty;
    assign pop       = dec_valid && dec_ready;
    // A simultaneous pop frees a slot, so a full FIFO can still accept a fetch.
    assign imem_read = running && (!full || pop) && !redirect;
    assign push      = imem_read;
    assign imem_addr = pc;

    assign dec_instr  = empty ? 16'h0000 : buf_instr[rd_ptr];
    assign dec_pc     = empty ? 8'h00    : buf_pc[rd_ptr];
    assign fifo_count = count;

    // ------------------------------------------------------------------
    // PC, pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Flush: any pop this cycle is discarded along with the rest.
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 8'd1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; entries are only observable once
    // count marks them valid, and empty reads are forced to zero above.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= pc;
        end
    end

endmodule
